// File: rtl/cpu_pkg.sv
// Shared core definitions: default datapath sizes, register address type and
// the architectural zero register, used by decode, register file and writeback.
package cpu_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 8;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Register index that is hardwired to zero when the option is enabled
    localparam reg_addr_t REG_ZERO = '0;

    // True when an address names a physically present register
    function automatic logic addr_in_range(input int addr, input int num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Register file bus: two read ports with operand-ready, one writeback port,
// one issue port and the pending-write vector seen by the control FSM.
interface regfile_2r1w_sb_if
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0]   rd_addr_a;
    logic [DATA_W-1:0]   rd_data_a;
    logic                rd_rdy_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_b;
    logic                rd_rdy_b;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                iss_en;
    logic [ADDR_W-1:0]   iss_addr;
    logic [NUM_REGS-1:0] busy_vec;

    // Decode/control and writeback side
    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b, busy_vec
    );

    // Register file side
    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data_a, rd_rdy_a, rd_data_b, rd_rdy_b, busy_vec
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: selects a register from the flattened array,
// blanks out-of-range and zero-register reads, forwards same-cycle writeback
// data and reports whether the operand is free of a pending write.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  ZERO_REG = 0,
    parameter int  BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]          addr,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]        pending,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          data,
    output logic                       rdy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] sel_data;
    logic              sel_pend;
    logic              in_range;
    logic              zero_hit;
    logic              bypass_hit;

    // Plain array lookup; a loop over present registers keeps every index legal
    always_comb begin
        sel_data = '0;
        sel_pend = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                sel_data = regs_flat[i*DATA_W +: DATA_W];
                sel_pend = pending[i];
            end
        end
    end

    // Classify the address and detect a forwardable writeback to it
    always_comb begin
        in_range   = addr_in_range(32'(addr), NUM_REGS);
        zero_hit   = (ZERO_REG != 0) && (addr == ZERO_ADDR);
        bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == addr) && in_range && !zero_hit;
    end

    // Final data/ready: absent or zero registers read 0 and are always ready
    always_comb begin
        data = '0;
        rdy  = 1'b1;
        if (in_range && !zero_hit) begin
            if (bypass_hit) begin
                data = wr_data;
                rdy  = 1'b1;
            end else begin
                data = sel_data;
                rdy  = ~sel_pend;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// CPU register file with two read ports, one write port and a pending-write
// scoreboard: issue marks a destination busy, writeback clears it, and the
// read ports report operand readiness. The interface parameters must match
// DATA_W and NUM_REGS of this module.
module regfile_2r1w_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_2r1w_sb_if.slave   bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        pending;
    logic [NUM_REGS-1:0]        pending_next;
    logic                       wr_ok;
    logic                       iss_ok;

    // A destination is real only if present and not the hardwired zero register
    function automatic logic valid_dest(input logic [ADDR_W-1:0] a);
        return addr_in_range(32'(a), NUM_REGS) &&
               !((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO)));
    endfunction

    // Qualify the write and issue strobes against their target addresses
    always_comb begin
        wr_ok  = bus.wr_en  && valid_dest(bus.wr_addr);
        iss_ok = bus.iss_en && valid_dest(bus.iss_addr);
    end

    // Register array: writeback lands at the edge, reset clears every register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    // Scoreboard update: writeback clears, issue sets, and a new issue to the
    // same register wins because it names a newer producer
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                pending_next[i] = 1'b0;
            end
            if (iss_ok && (bus.iss_addr == ADDR_W'(i))) begin
                pending_next[i] = 1'b1;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Flatten the array so both read ports can share it through one port
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    assign bus.busy_vec = pending;

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .addr      (bus.rd_addr_a),
        .regs_flat (regs_flat),
        .pending   (pending),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .data      (bus.rd_data_a),
        .rdy       (bus.rd_rdy_a)
    );

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .addr      (bus.rd_addr_b),
        .regs_flat (regs_flat),
        .pending   (pending),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .data      (bus.rd_data_b),
        .rdy       (bus.rd_rdy_b)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: two instances share one stimulus stream,
// config 0 = 8 regs, no zero reg, bypass; config 1 = 6 regs, zero reg, no bypass.
module tb_regfile_2r1w_sb;

    logic       clk;
    logic       rst_n;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       iss_en;
    logic [2:0] iss_addr;

    int checks;
    int errors;
    bit cmp_en;

    logic [7:0] m_reg  [2][8];
    logic       m_pend [2][8];

    regfile_2r1w_sb_if #(.DATA_W(8), .NUM_REGS(8)) if0 ();
    regfile_2r1w_sb_if #(.DATA_W(8), .NUM_REGS(6)) if1 ();

    assign if0.rd_addr_a = rd_addr_a;
    assign if0.rd_addr_b = rd_addr_b;
    assign if0.wr_en     = wr_en;
    assign if0.wr_addr   = wr_addr;
    assign if0.wr_data   = wr_data;
    assign if0.iss_en    = iss_en;
    assign if0.iss_addr  = iss_addr;
    assign if1.rd_addr_a = rd_addr_a;
    assign if1.rd_addr_b = rd_addr_b;
    assign if1.wr_en     = wr_en;
    assign if1.wr_addr   = wr_addr;
    assign if1.wr_data   = wr_data;
    assign if1.iss_en    = iss_en;
    assign if1.iss_addr  = iss_addr;

    regfile_2r1w_sb #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    regfile_2r1w_sb #(.DATA_W(8), .NUM_REGS(6), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: configuration properties
    function automatic int cfg_nregs(input int c);
        return (c == 0) ? 8 : 6;
    endfunction

    function automatic bit cfg_zero(input int c);
        return c != 0;
    endfunction

    function automatic bit cfg_bypass(input int c);
        return c == 0;
    endfunction

    // A register that exists and can hold a value
    function automatic bit real_reg(input int c, input logic [2:0] a);
        return (int'(a) < cfg_nregs(c)) && !(cfg_zero(c) && a == 3'd0);
    endfunction

    function automatic logic [7:0] exp_data(input int c, input logic [2:0] a);
        if (!real_reg(c, a)) return 8'h00;
        if (cfg_bypass(c) && wr_en && wr_addr == a) return wr_data;
        return m_reg[c][a];
    endfunction

    function automatic logic [7:0] exp_rdy(input int c, input logic [2:0] a);
        if (!real_reg(c, a)) return 8'h01;
        if (cfg_bypass(c) && wr_en && wr_addr == a) return 8'h01;
        return {7'b0, ~m_pend[c][a]};
    endfunction

    function automatic logic [7:0] exp_busy(input int c);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < cfg_nregs(c); i++) v[i] = m_pend[c][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[c][i]  = 8'h00;
                m_pend[c][i] = 1'b0;
            end
        end
    endtask

    // Clock edge in the model: write then issue, so issue wins on a collision
    task automatic model_update();
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (wr_en && real_reg(c, wr_addr)) begin
                    m_reg[c][wr_addr]  = wr_data;
                    m_pend[c][wr_addr] = 1'b0;
                end
                if (iss_en && real_reg(c, iss_addr)) m_pend[c][iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                  input logic ie, input logic [2:0] ia,
                                  input logic [2:0] ra, input logic [2:0] rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        iss_en    = ie;
        iss_addr  = ia;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Continuous comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("c0 data_a", if0.rd_data_a, exp_data(0, rd_addr_a));
            check_output("c0 rdy_a", {7'b0, if0.rd_rdy_a}, exp_rdy(0, rd_addr_a));
            check_output("c0 data_b", if0.rd_data_b, exp_data(0, rd_addr_b));
            check_output("c0 rdy_b", {7'b0, if0.rd_rdy_b}, exp_rdy(0, rd_addr_b));
            check_output("c0 busy", if0.busy_vec, exp_busy(0));
            check_output("c1 data_a", if1.rd_data_a, exp_data(1, rd_addr_a));
            check_output("c1 rdy_a", {7'b0, if1.rd_rdy_a}, exp_rdy(1, rd_addr_a));
            check_output("c1 data_b", if1.rd_data_b, exp_data(1, rd_addr_b));
            check_output("c1 rdy_b", {7'b0, if1.rd_rdy_b}, exp_rdy(1, rd_addr_b));
            check_output("c1 busy", {2'b00, if1.busy_vec}, exp_busy(1));
        end
    end

    // Directed scenarios with literal expectations, then randomized traffic
    initial begin
        logic [7:0] c1_final [6];
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        model_reset();
        tick();
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Reset mid-cycle after loading r3
        apply_stimulus(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd3);
        #1;
        check_output("r3 loaded", if0.rd_data_a, 8'hA5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("reset data_a", if0.rd_data_a, 8'h00);
        check_output("reset busy", if0.busy_vec, 8'h00);
        check_output("reset rdy_a", {7'b0, if0.rd_rdy_a}, 8'h01);
        check_output("reset rdy_b", {7'b0, if0.rd_rdy_b}, 8'h01);
        tick();
        rst_n = 1'b1;

        // Write then read from both ports
        apply_stimulus(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd5);
        #2;
        check_output("wr/rd c0 a", if0.rd_data_a, 8'h3C);
        check_output("wr/rd c0 b", if0.rd_data_b, 8'h3C);
        check_output("wr/rd c1 a", if1.rd_data_a, 8'h3C);
        check_output("wr/rd c1 b", if1.rd_data_b, 8'h3C);
        tick();

        // Bypass versus no bypass
        apply_stimulus(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        apply_stimulus(1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 3'd2, 3'd1);
        #2;
        check_output("bypass c0", if0.rd_data_a, 8'h77);
        check_output("nobypass c1", if1.rd_data_a, 8'h11);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd1);
        #2;
        check_output("after edge c1", if1.rd_data_a, 8'h77);
        tick();

        // Scoreboard set and clear
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd0);
        #2;
        check_output("pre-issue rdy c0", {7'b0, if0.rd_rdy_a}, 8'h01);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0);
        #2;
        check_output("busy4 c0", {7'b0, if0.busy_vec[4]}, 8'h01);
        check_output("rdy4 c0", {7'b0, if0.rd_rdy_a}, 8'h00);
        check_output("rdy4 c1", {7'b0, if1.rd_rdy_a}, 8'h00);
        apply_stimulus(1'b1, 3'd4, 8'h09, 1'b0, 3'd0, 3'd4, 3'd0);
        #1;
        check_output("wb bypass rdy c0", {7'b0, if0.rd_rdy_a}, 8'h01);
        check_output("wb bypass data c0", if0.rd_data_a, 8'h09);
        check_output("wb rdy c1", {7'b0, if1.rd_rdy_a}, 8'h00);
        check_output("wb old data c1", if1.rd_data_a, 8'h00);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0);
        #2;
        check_output("busy4 clr c0", {7'b0, if0.busy_vec[4]}, 8'h00);
        check_output("busy4 clr c1", {7'b0, if1.busy_vec[4]}, 8'h00);
        check_output("r4 c0", if0.rd_data_a, 8'h09);
        tick();

        // Same-edge issue and write to one register
        apply_stimulus(1'b1, 3'd6, 8'hF0, 1'b1, 3'd6, 3'd6, 3'd0);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd0);
        #2;
        check_output("collide data c0", if0.rd_data_a, 8'hF0);
        check_output("collide busy c0", {7'b0, if0.busy_vec[6]}, 8'h01);
        check_output("collide rdy c0", {7'b0, if0.rd_rdy_a}, 8'h00);
        check_output("oor data c1", if1.rd_data_a, 8'h00);
        check_output("oor rdy c1", {7'b0, if1.rd_rdy_a}, 8'h01);
        tick();

        // Zero register and out-of-range addresses
        apply_stimulus(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd7);
        #2;
        check_output("zero rd c1", if1.rd_data_a, 8'h00);
        check_output("zero rdy c1", {7'b0, if1.rd_rdy_a}, 8'h01);
        check_output("addr7 data c1", if1.rd_data_b, 8'h00);
        check_output("addr7 rdy c1", {7'b0, if1.rd_rdy_b}, 8'h01);
        check_output("r0 bypass c0", if0.rd_data_a, 8'hFF);
        tick();
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd7);
        #2;
        check_output("zero after c1", if1.rd_data_a, 8'h00);
        check_output("busy c1", {2'b00, if1.busy_vec}, 8'h00);
        check_output("busy c0", if0.busy_vec, 8'h41);
        tick();
        apply_stimulus(1'b1, 3'd7, 8'h5A, 1'b1, 3'd7, 3'd0, 3'd0);
        tick();
        c1_final = '{8'h00, 8'h00, 8'h77, 8'h00, 8'h09, 8'h3C};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(i), 3'd7);
            #2;
            check_output($sformatf("c1 r%0d kept", i), if1.rd_data_a, c1_final[i]);
            tick();
        end
        check_output("r7 c0", if0.rd_data_b, 8'h5A);
        check_output("busy7 c1 none", {2'b00, if1.busy_vec}, 8'h00);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                           1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
            end
            tick();
            rst_n = 1'b1;
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
